// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serialiser.
// The FSM has one bit of state: a frame is either in flight or not.
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Width of a counter that indexes every bit of a word (at least one bit).
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Serialises one word per frame, advancing one bit per Shift_Strobe_In; first bit shows the cycle after accept.
// Load_Ready_Out is high when idle or on the strobe that consumes the last bit, so frames can run back to back.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic                  Load_Valid_In,
  output logic                  Load_Ready_Out,
  input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
  input  logic                  Shift_Strobe_In,
  output logic                  Serial_Data_Out,
  output logic                  Serial_Valid_Out,
  output logic                  Busy_Out,
  output logic                  Done_Out
);

  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done_q, done_d;

  logic is_shift;
  logic advance;
  logic last_strobe;
  logic accept;
  logic ser_bit;

  assign is_shift    = (state_q == ST_SHIFT);
  assign advance     = Enable_In & is_shift & Shift_Strobe_In;
  assign last_strobe = advance & (cnt_q == LAST_CNT);

  // Ready on the last-bit strobe lets the next word load in the same cycle.
  assign Load_Ready_Out = Enable_In & (~is_shift | last_strobe);
  assign accept         = Load_Valid_In & Load_Ready_Out;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = last_strobe;
    if (accept) begin
      state_d = ST_SHIFT;
      shreg_d = Parallel_Data_In;
      cnt_d   = '0;
    end else if (advance) begin
      if (MSB_FIRST) begin
        shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
      end else begin
        shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
      end
      if (last_strobe) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign ser_bit          = MSB_FIRST ? shreg_q[DATA_WIDTH-1] : shreg_q[0];
  assign Serial_Data_Out  = !Enable_In ? 1'bz : (is_shift ? ser_bit : IDLE_LEVEL);
  assign Serial_Valid_Out = is_shift & Enable_In;
  assign Busy_Out         = is_shift & Enable_In;
  assign Done_Out         = done_q;

endmodule
